instcache_dm: RTL and testbench
===============================

# instcache_dm

Parametrised direct-mapped instruction cache between the fetch stage and instruction memory. Returns a FETCH_BYTES-wide window starting at any byte address, including windows that straddle two lines. Misses are refilled through a ready/ack memory handshake rather than a fixed delay. Adds a flush input and optional performance counters.

## Interface
- ADDR_W, 32, address width in bits
- LINE_BYTES, 32, bytes per line; power of 2, at least FETCH_BYTES
- SETS, 4, number of lines; power of 2, at least 2
- FETCH_BYTES, 4, bytes returned per fetch
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  fetch request
- req_addr  input  ADDR_W  byte address of the window
- req_ready  output  1  request accepted on an edge where valid and ready are both high
- resp_valid  output  1  one-cycle pulse carrying the response
- resp_data  output  FETCH_BYTES*8  bits [7:0] hold byte at req_addr, higher bytes ascending
- flush  input  1  invalidate all lines
- mem_req  output  1  line fill request, held until acked
- mem_addr  output  ADDR_W  line-aligned fill address
- mem_ack  input  1  mem_data valid this cycle
- mem_data  input  LINE_BYTES*8  bits [7:0] hold the byte at the line base

## Operation
- Address split: offset = low log2(LINE_BYTES) bits, index = next log2(SETS) bits, tag = the rest.
- Line A = req_addr with offset cleared.
- Line B = A + LINE_BYTES, modulo 2^ADDR_W. Line B is needed only when offset + FETCH_BYTES > LINE_BYTES.
- A and B always map to different sets.
- FSM states: IDLE, FILL_A, FILL_B.
  - IDLE: req_ready = !flush.
  - On accept, A and B are looked up against tag and valid.
  - All needed lines hit: stay in IDLE and register the response.
  - A misses: go to FILL_A.
  - Only B misses: go to FILL_B.
- FILL_A: mem_req = 1, mem_addr = A. On ack, write the line, tag and valid bit.
  - If B is needed and missing, go to FILL_B.
  - Otherwise go to IDLE and register the response.
- FILL_B: same as FILL_A with address B, then go to IDLE.
- The response is assembled from the array, bypassing mem_data for the line written on the same edge.
- flush in IDLE: clears all valid bits at the edge. No request is accepted that cycle.
- flush in FILL_x: latched as pending.
  - The fill and its response complete normally.
  - The pending flush clears all valid bits, including the just-filled lines, on the edge that returns to IDLE.
- mem_ack outside FILL_x is ignored.

## Timing
- Reset values: state IDLE, all valid bits 0, resp_valid 0, resp_data 0, mem_req 0, mem_addr 0, counters 0.
- Reset asserted mid-fill abandons the fill. mem_req drops asynchronously.
- Hit latency: accept at edge N gives resp_valid high for the cycle after N.
- Back-to-back hits give one response per cycle.
- Miss: mem_req rises in the cycle after accept. The earliest ack is on the next edge.
- resp_valid is high for the cycle after the final ack edge. req_ready is high in that same cycle.
- Single-line miss minimum latency is 2 cycles; double miss minimum is 3.
- mem_addr is stable while mem_req is high.

## Configuration
- ICACHE_PERF_EN defined:
  - 32-bit outputs hit_cnt and miss_cnt are present.
  - Each accepted request increments exactly one: miss_cnt if any fill is needed, else hit_cnt.
  - Both counters wrap at 2^32, reset to 0, and are unaffected by flush.
- ICACHE_PERF_EN undefined: the ports and logic are absent.

## Structure
- Package instcache_pkg holds:
  - state enum {IDLE, FILL_A, FILL_B}
  - clog2-derived width constants for offset, index and tag
  - line-address helper functions
- Sub-module instcache_align: combinational extractor taking two lines plus an offset and producing the FETCH_BYTES window. It is instantiated once.

## Test plan
Parameters for all scenarios: defaults, with mem_ack 3 cycles after each mem_req rise.
- After reset, request 0x40 → mem_req with mem_addr 0x40, then response bytes 0x40..0x43. Repeating 0x40 → resp_valid 1 cycle after accept, no mem_req.
- Request 0x5E with 0x40 cached → single fill at 0x60. Response = bytes 0x5E, 0x5F, 0x60, 0x61. hit_cnt 1, miss_cnt 2.
- 0x40, then 0xC0 (same set 2), then 0x40 → three fills; the third re-fetches 0x40.
- flush asserted during FILL_A for 0x100 → response still delivered. A following request to 0x100 misses. req_ready is low in any cycle with flush high.
- Request 0xFFFFFFFE → fills 0xFFFFFFE0, then 0x00000000. Response = bytes FE, FF, 00, 01 of their lines.
- rst_n pulsed low mid-fill → mem_req 0 immediately and resp_valid stays 0. The next request to the same line misses.

Source files
------------

// File: rtl/instcache_pkg.sv
// Shared types, default geometry and line-address helpers for the direct-mapped instruction cache.
package instcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL_A = 2'd1,
        FILL_B = 2'd2
    } state_t;

    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_LINE_BYTES  = 32;
    localparam int unsigned DEF_SETS        = 4;
    localparam int unsigned DEF_FETCH_BYTES = 4;
    localparam int unsigned DEF_OFF_W       = $clog2(DEF_LINE_BYTES);
    localparam int unsigned DEF_IDX_W       = $clog2(DEF_SETS);
    localparam int unsigned DEF_TAG_W       = DEF_ADDR_W - DEF_OFF_W - DEF_IDX_W;

    function automatic logic [63:0] line_base(input logic [63:0] addr, input int unsigned off_w);
        return addr & ~((64'd1 << off_w) - 64'd1);
    endfunction

    // Callers truncate to their address width, which gives the modulo-2^ADDR_W wrap.
    function automatic logic [63:0] next_line(input logic [63:0] addr, input int unsigned off_w);
        return line_base(addr, off_w) + (64'd1 << off_w);
    endfunction

endpackage

// File: rtl/instcache_align.sv
// Combinational window extractor: picks FETCH_BYTES bytes from the concatenation of two lines.
module instcache_align
    import instcache_pkg::*;
#(
    parameter int unsigned LINE_BYTES  = DEF_LINE_BYTES,
    parameter int unsigned FETCH_BYTES = DEF_FETCH_BYTES,
    parameter int unsigned OFF_W       = $clog2(LINE_BYTES)
) (
    input  logic [LINE_BYTES*8-1:0]  line_lo,
    input  logic [LINE_BYTES*8-1:0]  line_hi,
    input  logic [OFF_W-1:0]         offset,
    output logic [FETCH_BYTES*8-1:0] window
);

    assign window = (FETCH_BYTES*8)'({line_hi, line_lo} >> {offset, 3'b000});

endmodule

// File: rtl/instcache_dm.sv
// Direct-mapped instruction cache with line-straddling fetch windows and ready/ack refill.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module instcache_dm
    import instcache_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned LINE_BYTES  = DEF_LINE_BYTES,
    parameter int unsigned SETS        = DEF_SETS,
    parameter int unsigned FETCH_BYTES = DEF_FETCH_BYTES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    input  logic [ADDR_W-1:0]         req_addr,
    output logic                      req_ready,
    output logic                      resp_valid,
    output logic [FETCH_BYTES*8-1:0]  resp_data,
    input  logic                      flush,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_ack,
    input  logic [LINE_BYTES*8-1:0]   mem_data
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]               hit_cnt,
    output logic [31:0]               miss_cnt
`endif
);

    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned LINE_W = LINE_BYTES * 8;

    state_t                 state_r;
    logic [SETS-1:0]        valid_r;
    logic [TAG_W-1:0]       tag_r [SETS];
    logic [LINE_W-1:0]      data_r [SETS];
    logic [ADDR_W-1:0]      line_a_r;
    logic [ADDR_W-1:0]      line_b_r;
    logic [OFF_W-1:0]       off_r;
    logic                   fill_b_r;
    logic                   flush_pend_r;

    logic [ADDR_W-1:0]      line_a_s;
    logic [ADDR_W-1:0]      line_b_s;
    logic [OFF_W-1:0]       req_off_s;
    logic                   need_b_s;
    logic                   hit_a_s;
    logic                   hit_b_s;
    logic                   miss_a_s;
    logic                   miss_b_s;
    logic                   accept_s;
    logic [IDX_W-1:0]       cur_idx_a_s;
    logic [IDX_W-1:0]       cur_idx_b_s;
    logic [OFF_W-1:0]       cur_off_s;
    logic [LINE_W-1:0]      lo_s;
    logic [LINE_W-1:0]      hi_s;
    logic [FETCH_BYTES*8-1:0] win_s;
    logic                   fill_we_s;
    logic [IDX_W-1:0]       fill_idx_s;
    logic [TAG_W-1:0]       fill_tag_s;

    assign req_ready = (state_r == IDLE) && !flush;

    // Request decode and tag lookup for both candidate lines.
    always_comb begin
        req_off_s = req_addr[OFF_W-1:0];
        line_a_s  = ADDR_W'(line_base(64'(req_addr), OFF_W));
        line_b_s  = ADDR_W'(next_line(64'(req_addr), OFF_W));
        need_b_s  = ({1'b0, req_off_s} + (OFF_W+1)'(FETCH_BYTES)) > (OFF_W+1)'(LINE_BYTES);
        hit_a_s   = valid_r[line_a_s[OFF_W +: IDX_W]] &&
                    (tag_r[line_a_s[OFF_W +: IDX_W]] == line_a_s[ADDR_W-1 -: TAG_W]);
        hit_b_s   = valid_r[line_b_s[OFF_W +: IDX_W]] &&
                    (tag_r[line_b_s[OFF_W +: IDX_W]] == line_b_s[ADDR_W-1 -: TAG_W]);
        miss_a_s  = !hit_a_s;
        miss_b_s  = need_b_s && !hit_b_s;
        accept_s  = req_valid && req_ready;
    end

    // Window sources: live request when idle, latched request during fills, with mem_data bypass.
    always_comb begin
        if (state_r == IDLE) begin
            cur_idx_a_s = line_a_s[OFF_W +: IDX_W];
            cur_idx_b_s = line_b_s[OFF_W +: IDX_W];
            cur_off_s   = req_off_s;
        end else begin
            cur_idx_a_s = line_a_r[OFF_W +: IDX_W];
            cur_idx_b_s = line_b_r[OFF_W +: IDX_W];
            cur_off_s   = off_r;
        end
        if ((state_r == FILL_A) && mem_ack) begin
            lo_s = mem_data;
        end else begin
            lo_s = data_r[cur_idx_a_s];
        end
        if ((state_r == FILL_B) && mem_ack) begin
            hi_s = mem_data;
        end else begin
            hi_s = data_r[cur_idx_b_s];
        end
        fill_we_s = mem_ack && ((state_r == FILL_A) || (state_r == FILL_B));
        if (state_r == FILL_B) begin
            fill_idx_s = cur_idx_b_s;
            fill_tag_s = line_b_r[ADDR_W-1 -: TAG_W];
        end else begin
            fill_idx_s = cur_idx_a_s;
            fill_tag_s = line_a_r[ADDR_W-1 -: TAG_W];
        end
    end

    instcache_align #(
        .LINE_BYTES  (LINE_BYTES),
        .FETCH_BYTES (FETCH_BYTES),
        .OFF_W       (OFF_W)
    ) u_align (
        .line_lo (lo_s),
        .line_hi (hi_s),
        .offset  (cur_off_s),
        .window  (win_s)
    );

    // Line data and tag storage; contents are qualified by valid_r so no reset is needed.
    always_ff @(posedge clk) begin
        if (fill_we_s) begin
            data_r[fill_idx_s] <= mem_data;
            tag_r[fill_idx_s]  <= fill_tag_s;
        end
    end

    // Control FSM with registered response and memory request outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            valid_r      <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            line_a_r     <= '0;
            line_b_r     <= '0;
            off_r        <= '0;
            fill_b_r     <= 1'b0;
            flush_pend_r <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (flush) begin
                        valid_r <= '0;
                    end else if (accept_s) begin
                        line_a_r <= line_a_s;
                        line_b_r <= line_b_s;
                        off_r    <= req_off_s;
                        fill_b_r <= miss_b_s;
                        if (miss_a_s) begin
                            state_r  <= FILL_A;
                            mem_req  <= 1'b1;
                            mem_addr <= line_a_s;
                        end else if (miss_b_s) begin
                            state_r  <= FILL_B;
                            mem_req  <= 1'b1;
                            mem_addr <= line_b_s;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_data  <= win_s;
                        end
                    end
                end
                FILL_A, FILL_B: begin
                    if (mem_ack) begin
                        valid_r[fill_idx_s] <= 1'b1;
                    end
                    if (mem_ack && (state_r == FILL_A) && fill_b_r) begin
                        state_r      <= FILL_B;
                        mem_addr     <= line_b_r;
                        flush_pend_r <= flush_pend_r | flush;
                    end else if (mem_ack) begin
                        state_r      <= IDLE;
                        mem_req      <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_data    <= win_s;
                        flush_pend_r <= 1'b0;
                        // A deferred flush also discards the lines written by this fill.
                        if (flush_pend_r || flush) begin
                            valid_r <= '0;
                        end
                    end else if (flush) begin
                        flush_pend_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    mem_req      <= 1'b0;
                    flush_pend_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_EN
    // Per-request hit/miss accounting; flush does not touch the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else if (accept_s) begin
            if (miss_a_s || miss_b_s) begin
                miss_cnt <= miss_cnt + 32'd1;
            end else begin
                hit_cnt <= hit_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instcache_dm.sv
// Directed testbench for instcache_dm; memory returns line bytes equal to the low byte of each address.
module tb_instcache_dm;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         req_valid = 1'b0;
    logic [31:0]  req_addr  = 32'd0;
    logic         flush     = 1'b0;
    logic         mem_ack   = 1'b0;
    logic [255:0] mem_data  = '0;
    logic         req_ready;
    logic         resp_valid;
    logic [31:0]  resp_data;
    logic         mem_req;
    logic [31:0]  mem_addr;
`ifdef ICACHE_PERF_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int           n_assert = 0;
    int           n_fail   = 0;
    int           n_fills  = 0;
    int           ack_cnt  = 0;
    logic [31:0]  fill_log [0:31];

    always #5 clk = ~clk;

    instcache_dm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        logic [31:0]  a;
        l = '0;
        for (int i = 0; i < 32; i++) begin
            a = base + 32'(i);
            l[i*8 +: 8] = a[7:0];
        end
        return l;
    endfunction

    // Memory model: acknowledges on the third edge after a request is seen.
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end
        if (mem_req) begin
            ack_cnt++;
            if (ack_cnt == 3) begin
                mem_ack  = 1'b1;
                mem_data = mk_line(mem_addr);
                if (n_fills < 32) fill_log[n_fills] = mem_addr;
                n_fills++;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [31:0] a, output logic [31:0] data, output int lat,
                          output logic saw_req, output logic rdy);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        #1 rdy = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
        lat       = 1;
        saw_req   = mem_req;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            saw_req = saw_req | mem_req;
        end
        data = resp_data;
    endtask

    initial begin
        logic [31:0] d;
        int          lat;
        logic        sr;
        logic        rdy;
        logic        saw;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data",  resp_data, 32'h0);
        chk("rst_mem_req",    mem_req, 0);
        chk("rst_mem_addr",   mem_addr, 32'h0);
        chk("rst_req_ready",  req_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Cold miss then hit on the same line
        do_req(32'h40, d, lat, sr, rdy);
        chk("m40_ready", rdy, 1);
        chk("m40_memreq", sr, 1);
        chk("m40_lat", lat, 4);
        chk("m40_data", d, 32'h43424140);
        chk("m40_fills", n_fills, 1);
        chk("m40_addr", fill_log[0], 32'h40);
        do_req(32'h40, d, lat, sr, rdy);
        chk("h40_lat", lat, 1);
        chk("h40_memreq", sr, 0);
        chk("h40_data", d, 32'h43424140);
        @(negedge clk);
        chk("h40_pulse", resp_valid, 0);

        // Straddle: A hits, B at 0x60 misses
        do_req(32'h5E, d, lat, sr, rdy);
        chk("s5e_lat", lat, 4);
        chk("s5e_data", d, 32'h61605F5E);
        chk("s5e_fills", n_fills, 2);
        chk("s5e_addr", fill_log[1], 32'h60);
`ifdef ICACHE_PERF_EN
        chk("cnt_hit", hit_cnt, 32'd1);
        chk("cnt_miss", miss_cnt, 32'd2);
`endif

        // Back-to-back hits
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h44;
        @(negedge clk);
        req_addr = 32'h48;
        chk("b2b_v0", resp_valid, 1);
        chk("b2b_d0", resp_data, 32'h47464544);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_v1", resp_valid, 1);
        chk("b2b_d1", resp_data, 32'h4B4A4948);

        // Conflict in set 2
        do_req(32'hC0, d, lat, sr, rdy);
        chk("c0_lat", lat, 4);
        chk("c0_data", d, 32'hC3C2C1C0);
        chk("c0_addr", fill_log[2], 32'hC0);
        do_req(32'h40, d, lat, sr, rdy);
        chk("r40_lat", lat, 4);
        chk("r40_data", d, 32'h43424140);
        chk("r40_addr", fill_log[3], 32'h40);
        chk("r40_fills", n_fills, 4);

        // Flush during FILL_A
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b1;
        #1 chk("flush_fill_ready", req_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        lat   = 2;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("f100_lat", lat, 4);
        chk("f100_data", resp_data, 32'h03020100);
        chk("f100_addr", fill_log[4], 32'h100);
        do_req(32'h100, d, lat, sr, rdy);
        chk("f100_remiss", lat, 4);
        chk("f100_refill", fill_log[5], 32'h100);
        do_req(32'h100, d, lat, sr, rdy);
        chk("f100_hit", lat, 1);

        // Flush in IDLE blocks the request and clears lines
        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h100;
        #1 chk("flush_idle_ready", req_ready, 0);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("flush_idle_noresp", resp_valid, 0);
        do_req(32'h100, d, lat, sr, rdy);
        chk("fi100_lat", lat, 4);
        chk("fi100_fills", n_fills, 7);

        // Address wrap, double miss
        do_req(32'hFFFFFFFE, d, lat, sr, rdy);
        chk("wrap_lat", lat, 7);
        chk("wrap_data", d, 32'h0100FFFE);
        chk("wrap_addr_a", fill_log[7], 32'hFFFFFFE0);
        chk("wrap_addr_b", fill_log[8], 32'h00000000);

        // Reset mid-fill
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h200;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_memreq", mem_req, 1);
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_memreq", mem_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw   = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw = saw | resp_valid;
        end
        chk("mid_no_resp", saw, 0);
        chk("mid_no_fill", n_fills, 9);
        do_req(32'h200, d, lat, sr, rdy);
        chk("post_rst_lat", lat, 4);
        chk("post_rst_data", d, 32'h03020100);
        chk("post_rst_addr", fill_log[9], 32'h200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
